// File: rtl/countdown_pkg.sv
// Shared types for the two-digit BCD countdown timer: FSM states, digit type and digit limit.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;

  // Out-of-range BCD presets saturate to the largest legal digit.
  function automatic bcd_t clampDigit(input bcd_t d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler for the countdown timer: pulses tick on the last enabled cycle of every CLK_FREQ-cycle period.
module sec_tick_gen #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_FREQ - 1);

  logic [W-1:0] r_count;

  assign tick = en && (r_count == LAST);

  // Count only enabled cycles so a pause freezes the partial second exactly.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= tick ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with start/pause/clear control.
// Optional last-five-seconds Warn output enabled by defining COUNTDOWN_WARN_EN.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  input  logic [3:0] TimerH_Set,
  input  logic [3:0] TimerL_Set,
  output logic [3:0] TimerH,
  output logic [3:0] TimerL,
  output logic       Running,
  output logic       Time_Up,
  output logic       Warn
);

  state_t r_state;
  bcd_t   r_timerH;
  bcd_t   r_timerL;
  logic   r_timeUp;

  state_t w_nextState;
  bcd_t   w_nextH;
  bcd_t   w_nextL;
  logic   w_nextTimeUp;
  bcd_t   w_loadH;
  bcd_t   w_loadL;
  logic   w_active;
  logic   w_tick;
  logic   w_clr;
  logic   w_en;

  assign w_loadH  = clampDigit(TimerH_Set);
  assign w_loadL  = clampDigit(TimerL_Set);
  assign w_active = (r_state == RUN) || (r_state == PAUSED);
  assign w_clr    = Clear || Start;
  assign w_en     = w_active && !Pause && !w_clr;

  sec_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_sec_tick_gen (
    .CLK (CLK),
    .RSTn(RSTn),
    .clr (w_clr),
    .en  (w_en),
    .tick(w_tick)
  );

  always_comb begin
    w_nextState  = r_state;
    w_nextH      = r_timerH;
    w_nextL      = r_timerL;
    w_nextTimeUp = 1'b0;
    if (Clear) begin
      w_nextState = IDLE;
      w_nextH     = '0;
      w_nextL     = '0;
    end else if (Start) begin
      w_nextH = w_loadH;
      w_nextL = w_loadL;
      if ((w_loadH == '0) && (w_loadL == '0)) begin
        w_nextState  = DONE;
        w_nextTimeUp = 1'b1;
      end else begin
        w_nextState = RUN;
      end
    end else if (w_active) begin
      if (Pause) begin
        w_nextState = PAUSED;
      end else begin
        w_nextState = RUN;
        // A step from 01 lands on 00 and expires in the same cycle.
        if (w_tick) begin
          if (r_timerL != '0) begin
            w_nextL = r_timerL - 4'd1;
            if ((r_timerH == '0) && (r_timerL == 4'd1)) begin
              w_nextState  = DONE;
              w_nextTimeUp = 1'b1;
            end
          end else begin
            w_nextL = DIGIT_MAX;
            w_nextH = r_timerH - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= IDLE;
      r_timerH <= '0;
      r_timerL <= '0;
      r_timeUp <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_timerH <= w_nextH;
      r_timerL <= w_nextL;
      r_timeUp <= w_nextTimeUp;
    end
  end

  assign TimerH  = r_timerH;
  assign TimerL  = r_timerL;
  assign Running = w_active;
  assign Time_Up = r_timeUp;

`ifdef COUNTDOWN_WARN_EN
  logic r_warn;
  logic w_nextWarn;

  // Computed from next-state values so Warn changes on the same edge as the digits.
  assign w_nextWarn = ((w_nextState == RUN) || (w_nextState == PAUSED)) &&
                      (w_nextH == '0) && (w_nextL != '0) && (w_nextL <= 4'd5);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= w_nextWarn;
    end
  end

  assign Warn = r_warn;
`else
  assign Warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: behavioural seconds model, directed pins and random stimulus.
module tb_countdown_timer;

  localparam int CLK_FREQ = 10;
`ifdef COUNTDOWN_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic       Clear = 1'b0;
  logic [3:0] TimerH_Set = 4'd0;
  logic [3:0] TimerL_Set = 4'd0;
  logic [3:0] TimerH;
  logic [3:0] TimerL;
  logic       Running;
  logic       Time_Up;
  logic       Warn;

  int total = 0;
  int bad = 0;
  int timeUpSeen = 0;

  int mRem = 0;
  int mPhase = 0;
  bit mCounting = 1'b0;
  bit mTimeUp = 1'b0;

  countdown_timer #(
    .CLK_FREQ(CLK_FREQ)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Start     (Start),
    .Pause     (Pause),
    .Clear     (Clear),
    .TimerH_Set(TimerH_Set),
    .TimerL_Set(TimerL_Set),
    .TimerH    (TimerH),
    .TimerL    (TimerL),
    .Running   (Running),
    .Time_Up   (Time_Up),
    .Warn      (Warn)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int clampSet(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  // Reference: remaining seconds as an integer plus count of enabled cycles in the current second.
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mRem      = 0;
      mPhase    = 0;
      mCounting = 1'b0;
      mTimeUp   = 1'b0;
    end else begin
      mTimeUp = 1'b0;
      if (Clear) begin
        mRem      = 0;
        mPhase    = 0;
        mCounting = 1'b0;
      end else if (Start) begin
        mRem   = clampSet(TimerH_Set) * 10 + clampSet(TimerL_Set);
        mPhase = 0;
        if (mRem == 0) begin
          mCounting = 1'b0;
          mTimeUp   = 1'b1;
        end else begin
          mCounting = 1'b1;
        end
      end else if (mCounting && !Pause) begin
        mPhase++;
        if (mPhase == CLK_FREQ) begin
          mPhase = 0;
          mRem--;
          if (mRem == 0) begin
            mTimeUp   = 1'b1;
            mCounting = 1'b0;
          end
        end
      end
    end
  end

  function automatic bit modelWarn();
    return WARN_ON && mCounting && (mRem >= 1) && (mRem <= 5);
  endfunction

  always @(negedge CLK) begin
    if (Time_Up) timeUpSeen++;
    checkOutput("cycle", {1'b0, TimerH, TimerL, Running, Time_Up, Warn},
                {1'b0, 4'(mRem / 10), 4'(mRem % 10), mCounting, mTimeUp, modelWarn()});
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] h, input logic [3:0] l);
    TimerH_Set = h;
    TimerL_Set = l;
    Start = 1'b1;
    waitCycles(1);
    Start = 1'b0;
  endtask

  initial begin
    int tuBefore;
    waitCycles(1);
    checkOutput("reset", {1'b0, TimerH, TimerL, Running, Time_Up, Warn}, 12'h000);
    RSTn = 1'b1;
    waitCycles(2);

    // 12 down to 00, one step per CLK_FREQ cycles
    applyStimulus(4'd1, 4'd2);
    checkOutput("loadA", {TimerH, TimerL, Running}, {4'd1, 4'd2, 1'b1});
    for (int k = 1; k <= 12; k++) begin
      waitCycles(10);
      checkOutput("stepA", {TimerH, TimerL}, {4'((12 - k) / 10), 4'((12 - k) % 10)});
    end
    checkOutput("expireA", {Running, Time_Up}, 2'b01);
    waitCycles(1);
    checkOutput("doneA", {TimerH, TimerL, Running, Time_Up}, 12'h000);
    Pause = 1'b1;
    waitCycles(5);
    checkOutput("pauseInDone", {TimerH, TimerL, Running, Time_Up}, 12'h000);
    Pause = 1'b0;

    // zero preset expires immediately
    applyStimulus(4'd0, 4'd0);
    checkOutput("zeroExpire", {TimerH, TimerL, Running, Time_Up}, 12'h001);
    waitCycles(1);
    checkOutput("zeroAfter", {Running, Time_Up}, 2'b00);

    // 09 with 25 paused cycles starting 4 cycles after load
    applyStimulus(4'd0, 4'd9);
    waitCycles(3);
    Pause = 1'b1;
    waitCycles(25);
    Pause = 1'b0;
    checkOutput("pausedHold", {TimerH, TimerL, Running}, {4'd0, 4'd9, 1'b1});
    waitCycles(6);
    checkOutput("pauseC34", {TimerH, TimerL}, {4'd0, 4'd9});
    waitCycles(1);
    checkOutput("pauseC35", {TimerH, TimerL}, {4'd0, 4'd8});
    Clear = 1'b1;
    waitCycles(1);
    Clear = 1'b0;
    checkOutput("clearC", {TimerH, TimerL, Running}, 12'h000);

    // restart mid-count, clamped presets, Clear beats Start
    applyStimulus(4'd0, 4'd5);
    waitCycles(20);
    checkOutput("at03", {TimerH, TimerL}, {4'd0, 4'd3});
    applyStimulus(4'd2, 4'd0);
    checkOutput("reload20", {TimerH, TimerL, Running, Time_Up}, {4'd2, 4'd0, 1'b1, 1'b0});
    applyStimulus(4'hF, 4'hA);
    checkOutput("clamp99", {TimerH, TimerL, Running}, {4'd9, 4'd9, 1'b1});
    Clear = 1'b1;
    Start = 1'b1;
    TimerH_Set = 4'd3;
    waitCycles(1);
    Clear = 1'b0;
    Start = 1'b0;
    checkOutput("clearBeatsStart", {TimerH, TimerL, Running, Time_Up}, 12'h000);

    // reset at remaining 02
    applyStimulus(4'd0, 4'd4);
    waitCycles(20);
    checkOutput("at02", {TimerH, TimerL}, {4'd0, 4'd2});
    tuBefore = timeUpSeen;
    RSTn = 1'b0;
    #1;
    checkOutput("midReset", {1'b0, TimerH, TimerL, Running, Time_Up, Warn}, 12'h000);
    waitCycles(3);
    RSTn = 1'b1;
    waitCycles(30);
    checkOutput("afterReset", {TimerH, TimerL, Running}, 12'h000);
    checkOutput("noTimeUpOnReset", 12'(timeUpSeen - tuBefore), 12'h000);

    // Warn window
    applyStimulus(4'd0, 4'd7);
    checkOutput("warn07", {TimerH, TimerL, Warn}, {8'h07, 1'b0});
    waitCycles(19);
    checkOutput("warn06", {TimerH, TimerL, Warn}, {8'h06, 1'b0});
    waitCycles(1);
    checkOutput("warn05", {TimerH, TimerL, Warn}, {8'h05, WARN_ON});
    waitCycles(40);
    checkOutput("warn01", {TimerH, TimerL, Warn}, {8'h01, WARN_ON});
    waitCycles(10);
    checkOutput("warn00", {TimerH, TimerL, Time_Up, Warn}, {8'h00, 1'b1, 1'b0});

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Start = ($urandom_range(0, 999) < 10);
      Clear = ($urandom_range(0, 999) < 5);
      if ($urandom_range(0, 99) < 8) Pause = ~Pause;
      TimerH_Set = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      TimerL_Set = 4'($urandom_range(0, 15));
      RSTn = !($urandom_range(0, 999) < 3);
      waitCycles(1);
    end
    Start = 1'b0;
    Clear = 1'b0;
    Pause = 1'b0;
    RSTn = 1'b1;
    waitCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning CLK cycles per one-second countdown step.
REQ-002 SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port RSTn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port Start, input, 1 bit: sampled level; load presets and begin counting.
REQ-005 SHALL have port Pause, input, 1 bit: level; freezes countdown while high.
REQ-006 SHALL have port Clear, input, 1 bit: sampled level; abort and return to idle.
REQ-007 SHALL have port TimerH_Set, input, 4 bits: preset tens digit, BCD.
REQ-008 SHALL have port TimerL_Set, input, 4 bits: preset units digit, BCD.
REQ-009 SHALL have port TimerH, output, 4 bits: remaining tens digit, BCD.
REQ-010 SHALL have port TimerL, output, 4 bits: remaining units digit, BCD.
REQ-011 SHALL have port Running, output, 1 bit: high in RUN and PAUSED states.
REQ-012 SHALL have port Time_Up, output, 1 bit: one-cycle pulse on expiry.
REQ-013 SHALL have port Warn, output, 1 bit: last-five-seconds indicator (see Configuration).

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSED and DONE.
REQ-015 SHALL apply input priority Clear > Start > Pause in every state.
REQ-016 SHALL go to IDLE on a Clear sample, with TimerH/TimerL = 0 and the prescaler zeroed.
REQ-017 SHALL, on a Start sample in any state, latch the presets and, from the next cycle, show them on TimerH/TimerL with Running = 1 and the prescaler zeroed; a Start during RUN restarts the count.
REQ-018 SHALL clamp a preset digit greater than 9 to 9 at load.
REQ-019 SHALL treat a preset of 00 at Start as immediate expiry: go to DONE and pulse Time_Up on the cycle after Start.
REQ-020 SHALL in RUN decrement the two-digit BCD value once every CLK_FREQ cycles, so the first decrement is CLK_FREQ cycles after the load cycle.
REQ-021 SHALL on units borrow (units = 0, tens > 0) set units to 9 and decrement tens.
REQ-022 SHALL, on the step to 00, assert Time_Up for exactly one cycle in the same cycle that TimerH/TimerL become 0, then enter DONE with Running = 0.
REQ-023 SHALL move RUN to PAUSED while Pause is high, holding the digits and the prescaler count, and return to RUN when Pause is low with no lost or extra cycles.
REQ-024 SHALL ignore Pause in IDLE and DONE.
REQ-025 SHALL hold 00 in DONE until Start or Clear.

Reset
REQ-026 SHALL, while RSTn is low, force state IDLE, TimerH = 0, TimerL = 0, Running = 0, Time_Up = 0, Warn = 0, prescaler = 0 and latched presets = 0.
REQ-027 SHALL abandon any count in progress on reset, with no Time_Up pulse generated.

Configuration
REQ-028 SHALL, with macro COUNTDOWN_WARN_EN defined, drive Warn high while Running = 1 and the remaining value is between 01 and 05 inclusive, with Warn registered and aligned to the digits.
REQ-029 SHALL, with COUNTDOWN_WARN_EN undefined, tie Warn to 0 and omit the compare logic.

Structure
REQ-030 SHALL place the state enum, the BCD digit typedef and the digit-maximum constant 9 in shared package countdown_pkg.
REQ-031 SHALL implement the prescaler as sub-module sec_tick_gen, with ports CLK, RSTn, clr, en and tick, parameterised by CLK_FREQ.

Verification (CLK_FREQ = 10)
REQ-032 SHALL cover: presets 1/2, Start -> 12, 11, 10, 09, ..., 01, 00 at 10-cycle intervals; Time_Up pulses one cycle with 00; DONE entered.
REQ-033 SHALL cover: presets 0/0, Start -> Time_Up on the next cycle, Running never high.
REQ-034 SHALL cover: presets 0/9, Pause high for 25 cycles starting 4 cycles after load -> first decrement to 08 at cycle 35.
REQ-035 SHALL cover: Start at remaining 03 with presets 2/0 -> digits reload to 20, no Time_Up; also presets F/A -> load as 99.
REQ-036 SHALL cover: Clear and Start asserted together during RUN -> IDLE with 00; RSTn low at remaining 02 -> all outputs 0, no Time_Up.
REQ-037 SHALL cover, with COUNTDOWN_WARN_EN defined: presets 0/7 -> Warn rises with 05 and falls with 00; without the macro, Warn stays 0.
